kmap_eval: RTL and testbench
============================

# kmap_eval

Registered 4-input Boolean function evaluator for a K-map simplification lab datapath. Each valid input vector {a,b,c,d} is looked up in a 16-entry truth table, and the block returns the function value one clock later. It also returns a flag marking whether the minterm is a designated don't-care. The truth table and don't-care mask reset to the minimized default function and can be reprogrammed at run time.

## Interface
Parameters:
- DEF_ON, 16'h888F, reset truth table; bit i is the output for minterm i = {a,b,c,d}. This is the resolved form of F = Σm(1,3,7,11,15) + d(0,2,5), which minimizes to c·d + a'·b'.
- DEF_DC, 16'h0025, reset don't-care mask (minterms 0, 2, 5).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies a, b, c, d this cycle.
- a  in  1  MSB of the minterm index.
- b  in  1  index bit 2.
- c  in  1  index bit 1.
- d  in  1  LSB of the minterm index.
- cfg_we  in  1  write strobe for the truth table and don't-care mask.
- cfg_on  in  16  new truth table; loaded when cfg_we=1.
- cfg_dc  in  16  new don't-care mask; loaded when cfg_we=1.
- k_out  out  1  registered function value.
- k_dc  out  1  registered don't-care flag for the evaluated minterm.
- out_valid  out  1  k_out and k_dc are valid this cycle.

## Operation
- Index: idx = {a,b,c,d}, range 0..15. Minterm 0 is a=b=c=d=0.
- Evaluation, on a clock edge with in_valid=1:
  - k_out <= on_tbl[idx]
  - k_dc <= dc_tbl[idx]
  - out_valid <= 1
- On a clock edge with in_valid=0:
  - out_valid <= 0.
  - k_out and k_dc hold their previous values.
- Don't-care entries are not treated specially in the datapath. Their resolved value is whatever on_tbl holds. k_dc only reports that the minterm is a don't-care.
- Configuration, on a clock edge with cfg_we=1:
  - on_tbl <= cfg_on
  - dc_tbl <= cfg_dc
  - Both fields are written atomically; there is no partial write.
- Simultaneous cfg_we and in_valid: the evaluation uses the table contents from before the edge (old table). The new table applies from the next cycle onward.
- No combinational path from any input to any output.
- Reset, when rst=1 at a clock edge:
  - on_tbl <= DEF_ON, dc_tbl <= DEF_DC.
  - k_out <= 0, k_dc <= 0, out_valid <= 0.
  - Reset takes priority over cfg_we and in_valid in the same cycle.
  - Reset mid-stream discards the pending result and any pending write. Any custom table is lost.
- Default function values by minterm:
  - 0–3 → 1
  - 4–6 → 0
  - 7 → 1
  - 8–10 → 0
  - 11 → 1
  - 12–14 → 0
  - 15 → 1
- Inputs are 1-bit; there are no X-propagation requirements beyond standard RTL semantics.

## Timing
- Latency: exactly 1 clock from in_valid to out_valid with the matching k_out/k_dc.
- Throughput: one evaluation per clock. Back-to-back in_valid gives back-to-back out_valid.
- Config write latency: 1 clock. The first evaluation sampled on the edge after the write edge uses the new table.
- Outputs after reset: k_out=0, k_dc=0, out_valid=0 until the first valid input is sampled.
- No handshake backpressure: results are not held for a consumer. Each out_valid pulse lasts one cycle per input.

## Test plan
- Reset, then sweep idx 0..15 one per cycle with in_valid=1:
  - k_out sequence is 1,1,1,1,0,0,0,1,0,0,0,1,0,0,0,1.
  - k_dc=1 only for idx 0, 2, 5.
  - out_valid is high for 16 consecutive cycles, starting one cycle after the first input.
- Gapped inputs: apply idx 7, then in_valid=0 for 3 cycles.
  - k_out=1 and out_valid=1 for one cycle.
  - out_valid=0 afterward, with k_out holding 1.
- Reprogram the table with cfg_on=16'h0001, cfg_dc=16'h8000, then evaluate idx 0 and idx 15:
  - idx 0 → k_out=1, k_dc=0.
  - idx 15 → k_out=0, k_dc=1.
- Assert cfg_we (cfg_on=16'h0000) in the same cycle as in_valid with idx 3:
  - That result is k_out=1 (old table).
  - idx 3 applied on the next cycle gives k_out=0.
- Reprogram the table, stream inputs, then assert rst for 1 cycle mid-stream:
  - Next cycle shows out_valid=0, k_out=0, k_dc=0.
  - Subsequent idx 4 gives k_out=0 and idx 1 gives k_out=1, confirming the defaults are restored.
- rst and cfg_we asserted together, followed by evaluation of idx 11:
  - k_out=1, confirming reset priority and the default table.

Source files
------------

// File: rtl/kmap_if.sv
// kmap_if: evaluation and configuration signals of the K-map evaluator
interface kmap_if;
  logic        in_valid;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        cfg_we;
  logic [15:0] cfg_on;
  logic [15:0] cfg_dc;
  logic        k_out;
  logic        k_dc;
  logic        out_valid;
  modport master (output in_valid, a, b, c, d, cfg_we, cfg_on, cfg_dc, input k_out, k_dc, out_valid);
  modport slave (input in_valid, a, b, c, d, cfg_we, cfg_on, cfg_dc, output k_out, k_dc, out_valid);
endinterface

// File: rtl/kmap_eval.sv
// kmap_eval: registered 4-input truth-table lookup with reprogrammable table and don't-care flag
module kmap_eval #(
  parameter logic [15:0] DEF_ON = 16'h888F,
  parameter logic [15:0] DEF_DC = 16'h0025
) (
  input logic   clk,
  input logic   rst,
  kmap_if.slave bus
);
  logic [15:0] on_q, on_d, dc_q, dc_d;
  logic        k_out_q, k_out_d, k_dc_q, k_dc_d, vld_q, vld_d;
  logic [3:0]  idx;
  // next state: lookups read the pre-edge table, so a same-cycle write only affects later inputs
  always_comb begin
    idx     = {bus.a, bus.b, bus.c, bus.d};
    on_d    = bus.cfg_we ? bus.cfg_on : on_q;
    dc_d    = bus.cfg_we ? bus.cfg_dc : dc_q;
    k_out_d = bus.in_valid ? on_q[idx] : k_out_q;
    k_dc_d  = bus.in_valid ? dc_q[idx] : k_dc_q;
    vld_d   = bus.in_valid;
  end
  // state registers; reset restores the default function and clears outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      on_q    <= DEF_ON;
      dc_q    <= DEF_DC;
      k_out_q <= 1'b0;
      k_dc_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      on_q    <= on_d;
      dc_q    <= dc_d;
      k_out_q <= k_out_d;
      k_dc_q  <= k_dc_d;
      vld_q   <= vld_d;
    end
  end
  assign bus.k_out     = k_out_q;
  assign bus.k_dc      = k_dc_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_kmap_eval.sv
// tb_kmap_eval: directed and randomized checks of kmap_eval against a truth-table model
module tb_kmap_eval;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miss = 0;
  bit   chk_en = 1'b0;
  logic [15:0] on_m, dc_m;
  logic        eo, ed, ev;
  logic [15:0] def_on_lit, def_dc_lit;
  kmap_if bus();
  kmap_eval dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // reference: table lookup from the pre-edge contents, write takes effect afterwards
  always @(posedge clk) begin
    if (rst) begin
      on_m = 16'h888F;
      dc_m = 16'h0025;
      eo = 1'b0;
      ed = 1'b0;
      ev = 1'b0;
    end else begin
      if (bus.in_valid) begin
        eo = on_m[{bus.a, bus.b, bus.c, bus.d}];
        ed = dc_m[{bus.a, bus.b, bus.c, bus.d}];
      end
      ev = bus.in_valid;
      if (bus.cfg_we) begin
        on_m = bus.cfg_on;
        dc_m = bus.cfg_dc;
      end
    end
  end
  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (bus.k_out !== eo || bus.k_dc !== ed || bus.out_valid !== ev) begin
        miss++;
        $display("FAIL model t=%0t got out=%b dc=%b v=%b want out=%b dc=%b v=%b",
                 $time, bus.k_out, bus.k_dc, bus.out_valid, eo, ed, ev);
      end
    end
  end
  task automatic lit(input string name, input logic o, input logic dcf, input logic v);
    vectors++;
    if (bus.k_out !== o || bus.k_dc !== dcf || bus.out_valid !== v) begin
      miss++;
      $display("FAIL %s got out=%b dc=%b v=%b want out=%b dc=%b v=%b",
               name, bus.k_out, bus.k_dc, bus.out_valid, o, dcf, v);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [3:0] i, input logic we,
                      input logic [15:0] on, input logic [15:0] dcm);
    rst = r;
    bus.in_valid = v;
    {bus.a, bus.b, bus.c, bus.d} = i;
    bus.cfg_we = we;
    bus.cfg_on = on;
    bus.cfg_dc = dcm;
    @(negedge clk);
  endtask
  initial begin
    def_on_lit = 16'b1000_1000_1000_1111;
    def_dc_lit = 16'b0000_0000_0010_0101;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    lit("reset", 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 4'(i), 0, 0, 0);
      lit($sformatf("sweep%0d", i), def_on_lit[i], def_dc_lit[i], 1);
    end
    step(0, 1, 7, 0, 0, 0);
    lit("gap_idx7", 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      lit("gap_hold", 1, 0, 0);
    end
    step(0, 0, 0, 1, 16'h0001, 16'h8000);
    step(0, 1, 0, 0, 0, 0);
    lit("cfg_idx0", 1, 0, 1);
    step(0, 1, 15, 0, 0, 0);
    lit("cfg_idx15", 0, 1, 1);
    step(0, 0, 0, 1, 16'h888F, 16'h0025);
    step(0, 1, 3, 1, 16'h0000, 16'h0000);
    lit("same_cycle_old", 1, 0, 1);
    step(0, 1, 3, 0, 0, 0);
    lit("same_cycle_new", 0, 0, 1);
    step(0, 0, 0, 1, 16'h7770, 16'hFFFF);
    step(0, 1, 4, 0, 0, 0);
    step(0, 1, 5, 0, 0, 0);
    step(1, 1, 6, 1, 16'hFFFF, 16'hFFFF);
    lit("mid_reset", 0, 0, 0);
    step(0, 1, 4, 0, 0, 0);
    lit("post_rst_idx4", 0, 0, 1);
    step(0, 1, 1, 0, 0, 0);
    lit("post_rst_idx1", 1, 0, 1);
    step(1, 0, 0, 1, 16'h0000, 16'h0000);
    step(0, 1, 11, 0, 0, 0);
    lit("rst_prio_idx11", 1, 0, 1);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 49) == 0, 1'($urandom), 4'($urandom), $urandom_range(0, 7) == 0,
           16'($urandom), 16'($urandom));
    step(0, 0, 0, 0, 0, 0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
